mips_cpu_muldiv: RTL
====================

Name: mips_cpu_muldiv

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS32 CPU.
- Sits directly downstream of the register file (mips_cpu_registers).
- Consumes rdDataA/rdDataB as operands and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the architectural HI/LO registers.
- The CPU stalls on busy before issuing another muldiv op or an MFHI/MFLO.

Parameters:
- ITERATIONS, 32, number of shift-add / restoring-divide steps; must equal the operand width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  op request, valid for one cycle.
- op  input  3  operation code (op_t from the package).
- opA  input  32  rs value (multiplicand / dividend / MTHI-MTLO source).
- opB  input  32  rt value (multiplier / divisor).
- busy  output  1  high while an iterative op is in flight.
- done  output  1  one-cycle pulse when HI/LO hold a new mult/div result.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (synchronous, active-high, on clock clk): at the next edge, state=IDLE, hi=0, lo=0, busy=0, done=0. Reset dominates start.
- Acceptance: an op is accepted at an edge where start=1, busy=0 and reset=0.
  - start while busy=1 is ignored. No queueing; state and HI/LO are unaffected.
  - op=NOP, or an unused code, with start=1 is ignored.
- MTHI/MTLO: single cycle. hi (or lo) <= opA at the accept edge. busy stays 0 and done is not pulsed.
- States:
  - IDLE -> RUN on an accepted mult/div op. Latch the abs values (signed ops) or raw values (unsigned ops) of opA/opB, plus the result-sign flags.
  - RUN: one iteration per edge, with an internal 6-bit counter. After ITERATIONS edges -> FIX.
  - FIX: apply sign correction and write hi/lo. -> IDLE with done=1 during the following cycle.
- Latency: accept at edge E0; iterations at E1..E32; hi/lo updated at E33; done=1 in the cycle after E33.
  - busy=1 from after E0 until E33 (33 cycles). busy=0 in the done cycle.
  - A new start is legal in the done cycle.
- hi/lo hold their old values throughout RUN; they are never partially updated.
- Multiply: 64-bit shift-add accumulator on 32-bit magnitudes.
  - MULT negates the 64-bit product when sign(opA) != sign(opB).
  - hi = product[63:32], lo = product[31:0].
- Divide: restoring division on magnitudes.
  - lo = quotient. The quotient is negated for DIV when the operand signs differ.
  - hi = remainder. The remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- Divide by zero (DIV and DIVU): lo=0xFFFFFFFF, hi=opA as latched. Takes the same 33-cycle latency. No exception.
- Reset mid-operation: the op is aborted, HI/LO are cleared and done is never pulsed for that op.
- Operands are sampled only at the accept edge. Later changes to opA/opB are ignored.

Decomposition:
- Package mips_cpu_muldiv_pkg holds:
  - typedef enum logic[2:0] op_t: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - state enum: IDLE, RUN, FIX.
  - localparam DATA_W=32.
- Single module, no sub-module. The datapath is a 64-bit accumulator/remainder register plus a 32-bit operand register, shared between mult and div.

Test Plan:
1. MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done pulses exactly 34 cycles after the accept edge. busy=1 for 33 cycles.
2. MULT opA=0xFFFFFFFD (-3), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
4. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234.
5. MTHI 0x12345678 -> hi=0x12345678 the next cycle, busy stays 0. Then during a DIV, MTLO 0xAAAA and a second start are both ignored; the final lo is the DIV quotient.
6. Reset asserted 10 cycles into a DIV -> the next cycle has busy=0, hi=lo=0. done does not pulse. A subsequent MULTU 3*5 gives lo=15, hi=0.
- Randomised mode: a shadow HI/LO model is compared after every done and every MTHI/MTLO.

Source files
------------

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the MIPS32 HI/LO multiply/divide unit.
package mips_cpu_muldiv_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } op_t;

    // Sequencer state encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, sharing one 64-bit accumulator and operand register.
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int ITERATIONS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  op_t               op,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic [1:0]          state;
    logic [5:0]          count;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opr;
    logic                is_div;
    logic                res_neg;   // product / quotient negation
    logic                rem_neg;   // remainder follows dividend sign
    logic                div_zero;

    logic                a_neg, b_neg;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     rem_trial;
    logic [2*DATA_W-1:0] step_next;

    assign busy = (state != IDLE);

    always_comb begin
        a_neg     = ((op == MULT) || (op == DIV)) && opA[DATA_W-1];
        b_neg     = ((op == MULT) || (op == DIV)) && opB[DATA_W-1];
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opr};
        rem_trial = acc[2*DATA_W-1:DATA_W-1];
        step_next = '0;
        if (is_div) begin
            // Shift the remainder:dividend pair left, subtract when the divisor fits.
            if (rem_trial >= {1'b0, opr})
                step_next = {rem_trial[DATA_W-1:0] - opr, acc[DATA_W-2:0], 1'b1};
            else
                step_next = {acc[2*DATA_W-2:0], 1'b0};
        end else begin
            if (acc[0])
                step_next = {mul_sum, acc[DATA_W-1:1]};
            else
                step_next = {1'b0, acc[2*DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opr      <= '0;
            is_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MULT, MULTU, DIV, DIVU: begin
                                state    <= RUN;
                                count    <= '0;
                                is_div   <= (op == DIV) || (op == DIVU);
                                res_neg  <= a_neg ^ b_neg;
                                rem_neg  <= a_neg;
                                div_zero <= (opB == '0);
                                acc      <= {{DATA_W{1'b0}}, magnitude(opA, a_neg)};
                                opr      <= magnitude(opB, b_neg);
                            end
                            MTHI:    hi <= opA;
                            MTLO:    lo <= opA;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc   <= step_next;
                    count <= count + 6'd1;
                    if (count == 6'(ITERATIONS - 1))
                        state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (is_div) begin
                        // Divide by zero keeps the all-ones quotient regardless of signs.
                        lo <= magnitude(acc[DATA_W-1:0], res_neg && !div_zero);
                        hi <= magnitude(acc[2*DATA_W-1:DATA_W], rem_neg);
                    end else begin
                        {hi, lo} <= res_neg ? (~acc + 1'b1) : acc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
